memory_arbiter: RTL and testbench

Sequential arbiter that shares the single RAM port between the instruction-fetch requester and the data-memory requester. It grants one transaction at a time, runs it to completion or timeout, and returns the `iwait`/`dwait` responses that become the `ihit`/`dhit` inputs of the pipeline stall logic. It sits between the datapath's cache/request interface and the RAM model, inside the memory-control layer.

---
 rtl/memory_arbiter.sv | 147 ++++++++++++++
 tb/tb_memory_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data memory requesters.
// Optional `MEM_ARB_RR_EN selects round-robin arbitration instead of data-first priority.
module memory_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              mem_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] IACC = 2'd1;
    localparam logic [1:0] DACC = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [7:0]        TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] BAD_DATA = DATA_W'(32'hBAD1BAD1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_store;
    logic              hold_wr;
    logic [7:0]        wait_cnt;

    logic dreq;
    logic ram_acc;
    logic ram_fail;
    logic icomplete;
    logic dcomplete;
    logic grant_d;
    logic grant_i;

    assign dreq    = dREN | dWEN;
    assign ram_acc = (ramstate == RAM_ACCESS);
    // The cycle holding count TIMEOUT-1 is the last one allowed; ACCESS on it still wins.
    assign ram_fail = !ram_acc && ((ramstate == RAM_ERROR) || (wait_cnt == TMO_LAST));

    assign icomplete = (state == IACC) && iREN && (ram_acc || ram_fail);
    assign dcomplete = (state == DACC) && dreq && (ram_acc || ram_fail);

`ifdef MEM_ARB_RR_EN
    logic last_d;

    assign grant_d = dreq && (!iREN || !last_d);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_d <= 1'b0;
        end else if (state == IDLE && (dreq || iREN)) begin
            last_d <= grant_d;
        end
    end
`else
    assign grant_d = dreq;
`endif

    assign grant_i = iREN && !grant_d;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = DACC;
                end else if (grant_i) begin
                    state_nxt = IACC;
                end
            end
            IACC:    if (!iREN || icomplete) state_nxt = IDLE;
            DACC:    if (!dreq || dcomplete) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            hold_addr  <= '0;
            hold_store <= '0;
            hold_wr    <= 1'b0;
            wait_cnt   <= '0;
            mem_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                wait_cnt <= '0;
                if (grant_d) begin
                    hold_addr  <= daddr;
                    hold_store <= dstore;
                    hold_wr    <= dWEN;
                end else if (grant_i) begin
                    hold_addr  <= iaddr;
                    hold_store <= '0;
                    hold_wr    <= 1'b0;
                end
            end else if (!ram_acc) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if ((icomplete || dcomplete) && ram_fail) begin
                mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        ramREN   = (state == IACC) || ((state == DACC) && !hold_wr);
        ramWEN   = (state == DACC) && hold_wr;
        ramaddr  = hold_addr;
        ramstore = hold_store;
        iwait    = iREN & !icomplete;
        dwait    = dreq & !dcomplete;
        iload    = '0;
        dload    = '0;
        if (icomplete) begin
            iload = ram_fail ? BAD_DATA : ramload;
        end
        if (dcomplete) begin
            if (ram_fail) begin
                dload = BAD_DATA;
            end else if (!hold_wr) begin
                dload = ramload;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: stimulus pushes expected load data,
// a negedge monitor pops and compares on every completion pulse.
module tb_memory_arbiter;

    localparam int TMO = 16;
    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic        clk;
    logic        nrst;
    logic        i_ren;
    logic [31:0] i_addr;
    logic [31:0] i_load;
    logic        i_wait;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_store;
    logic [31:0] d_load;
    logic        d_wait;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic [1:0]  ram_state;
    logic        merr;

    typedef struct {
        logic        chk;
        logic [31:0] val;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];

    int n_cmp = 0;
    int n_bad = 0;

    memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .CLK      (clk),
        .nRST     (nrst),
        .iREN     (i_ren),
        .iaddr    (i_addr),
        .iload    (i_load),
        .iwait    (i_wait),
        .dREN     (d_ren),
        .dWEN     (d_wen),
        .daddr    (d_addr),
        .dstore   (d_store),
        .dload    (d_load),
        .dwait    (d_wait),
        .ramREN   (ram_ren),
        .ramWEN   (ram_wen),
        .ramaddr  (ram_addr),
        .ramstore (ram_store),
        .ramload  (ram_load),
        .ramstate (ram_state),
        .mem_err  (merr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (nrst) begin
            if (i_ren && !i_wait) begin
                if (iq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL i_unexpected: got completion with iload 0x%08h, required none", i_load);
                end else begin
                    exp_t e;
                    e = iq.pop_front();
                    if (e.chk) check("iload", i_load, e.val);
                end
            end
            if ((d_ren || d_wen) && !d_wait) begin
                if (dq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL d_unexpected: got completion with dload 0x%08h, required none", d_load);
                end else begin
                    exp_t e;
                    e = dq.pop_front();
                    if (e.chk) check("dload", d_load, e.val);
                end
            end
        end
    end

    // Counts negedges with wait high until the completion pulse, then drops the request.
    task automatic wait_side(input bit is_d, input int max_cyc, output int stalls);
        bit done;
        done   = 1'b0;
        stalls = 0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(negedge clk);
            if (is_d ? d_wait : i_wait) stalls++;
            else done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_bound: got no completion in %0d cycles, required completion", is_d ? "d" : "i", max_cyc);
        end
        @(posedge clk);
        #1;
        if (is_d) begin
            d_ren = 1'b0;
            d_wen = 1'b0;
        end else begin
            i_ren = 1'b0;
        end
    endtask

    initial begin
        int st;
        nrst      = 1'b0;
        i_ren     = 1'b0;
        i_addr    = '0;
        d_ren     = 1'b0;
        d_wen     = 1'b0;
        d_addr    = '0;
        d_store   = '0;
        ram_load  = '0;
        ram_state = RS_FREE;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ramREN", 32'(ram_ren), 32'd0);
        check("rst_ramWEN", 32'(ram_wen), 32'd0);
        check("rst_ramaddr", ram_addr, 32'd0);
        check("rst_ramstore", ram_store, 32'd0);
        check("rst_mem_err", 32'(merr), 32'd0);
        check("rst_iload", i_load, 32'd0);
        check("rst_dload", d_load, 32'd0);
        @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait instruction fetch
        i_ren     = 1'b1;
        i_addr    = 32'h40;
        ram_state = RS_ACCESS;
        ram_load  = 32'h8C010004;
        iq.push_back('{1'b1, 32'h8C010004});
        @(posedge clk);
        #1;
        check("zw_ramREN", 32'(ram_ren), 32'd1);
        check("zw_ramaddr", ram_addr, 32'h40);
        wait_side(1'b0, 8, st);
        check("zw_stalls", 32'(st), 32'd0);
        check("zw_idle_ramREN", 32'(ram_ren), 32'd0);

        // Instruction and data write together: data first, fetch next
        i_ren    = 1'b1;
        i_addr   = 32'h44;
        d_wen    = 1'b1;
        d_addr   = 32'h100;
        d_store  = 32'hDEADBEEF;
        ram_load = 32'h12345678;
        dq.push_back('{1'b0, 32'h0});
        iq.push_back('{1'b1, 32'h12345678});
        @(posedge clk);
        #1;
        check("pair_ramWEN", 32'(ram_wen), 32'd1);
        check("pair_ramREN", 32'(ram_ren), 32'd0);
        check("pair_ramaddr", ram_addr, 32'h100);
        check("pair_ramstore", ram_store, 32'hDEADBEEF);
        check("pair_iwait", 32'(i_wait), 32'd1);
        wait_side(1'b1, 8, st);
        check("pair_d_stalls", 32'(st), 32'd0);
        wait_side(1'b0, 8, st);
        check("pair_i_stalls", 32'(st), 32'd1);

        // Abort: data read dropped while RAM busy
        d_ren     = 1'b1;
        d_addr    = 32'h300;
        ram_state = RS_BUSY;
        @(posedge clk);
        #1;
        check("abort_ramREN_granted", 32'(ram_ren), 32'd1);
        @(posedge clk);
        #1 d_ren = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ramREN", 32'(ram_ren), 32'd0);
        check("abort_ramWEN", 32'(ram_wen), 32'd0);
        check("abort_mem_err", 32'(merr), 32'd0);

        // Timeout: RAM stays busy for the whole budget
        d_ren  = 1'b1;
        d_addr = 32'h200;
        dq.push_back('{1'b1, 32'hBAD1BAD1});
        wait_side(1'b1, 40, st);
        check("tmo_stalls", 32'(st), 32'(TMO));
        check("tmo_mem_err", 32'(merr), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("tmo_mem_err_sticky", 32'(merr), 32'd1);

        // ERROR reported on the second IACC cycle
        i_ren  = 1'b1;
        i_addr = 32'h80;
        iq.push_back('{1'b1, 32'hBAD1BAD1});
        @(posedge clk);
        @(posedge clk);
        #1 ram_state = RS_ERROR;
        wait_side(1'b0, 4, st);
        check("err_stalls", 32'(st), 32'd0);
        check("err_mem_err", 32'(merr), 32'd1);
        ram_state = RS_BUSY;

        // Reset during a data write with an instruction fetch pending
        d_wen   = 1'b1;
        d_addr  = 32'h400;
        d_store = 32'h55;
        i_ren   = 1'b1;
        i_addr  = 32'h48;
        @(posedge clk);
        #1;
        check("rst_mid_ramWEN_granted", 32'(ram_wen), 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("rst_mid_ramWEN", 32'(ram_wen), 32'd0);
        check("rst_mid_ramREN", 32'(ram_ren), 32'd0);
        check("rst_mid_ramaddr", ram_addr, 32'd0);
        check("rst_mid_mem_err", 32'(merr), 32'd0);
        d_wen     = 1'b0;
        ram_state = RS_ACCESS;
        ram_load  = 32'hCAFEF00D;
        iq.push_back('{1'b1, 32'hCAFEF00D});
        @(posedge clk);
        #1 nrst = 1'b1;
        wait_side(1'b0, 8, st);
        check("post_rst_i_stalls", 32'(st), 32'd1);
        check("post_rst_ramREN", 32'(ram_ren), 32'd0);

        repeat (2) @(posedge clk);
        check("iq_drained", 32'(iq.size()), 32'd0);
        check("dq_drained", 32'(dq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
